mem_port_arbiter: RTL and testbench

- Shares one cpu32e2 memory transaction bus between two requesters: port 0 is instruction fetch, port 1 is data load/store.
- Commands are encoded in the transactionGroup controlBus format, 6 bits {read, write, bwe[3:0]}.
- Arbitration is round-robin; the winning command is registered onto the memory bus.
- Pipelined read responses return in order and are routed back to the requester that issued them, using a tag FIFO of outstanding reads.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter onto a single registered cpu32e2 memory bus.
// In-order read responses are routed back to their requester through a tag FIFO.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [5:0]        rq0_cmd,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    output logic              rq0_ready,
    output logic              rq0_rvalid,
    input  logic [5:0]        rq1_cmd,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq1_ready,
    output logic              rq1_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic [5:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wait,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam logic [5:0] CmdNoOp = 6'b000000;
    localparam logic [5:0] CmdRead = 6'b100000;
    localparam int unsigned PtrW   = $clog2(MAX_OUT);
    localparam int unsigned CntW   = $clog2(MAX_OUT) + 1;

    function automatic logic cmd_legal(input logic [5:0] c);
        case (c)
            6'b000000, 6'b100000,
            6'b011111, 6'b011100, 6'b010011,
            6'b011000, 6'b010100, 6'b010010, 6'b010001: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

    logic [5:0]        mem_cmd_q, mem_cmd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              last_grant_q, last_grant_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [MAX_OUT-1:0] tags_q, tags_d;

    logic legal0, legal1, slot_free, pop, push, read_room;
    logic elig0, elig1, gnt0, gnt1;

    always_comb begin
        legal0    = cmd_legal(rq0_cmd);
        legal1    = cmd_legal(rq1_cmd);
        slot_free = (mem_cmd_q == CmdNoOp) || !mem_wait;
        pop       = mem_rvalid && (count_q != '0);
        // A same-cycle pop frees the entry the new read will occupy.
        read_room = (count_q < CntW'(MAX_OUT)) || pop;

        elig0 = reset_n && slot_free && legal0 && (rq0_cmd != CmdNoOp) &&
                ((rq0_cmd != CmdRead) || read_room);
        elig1 = reset_n && slot_free && legal1 && (rq1_cmd != CmdNoOp) &&
                ((rq1_cmd != CmdRead) || read_room);

        gnt0 = elig0 && (!elig1 || last_grant_q);
        gnt1 = elig1 && !gnt0;
        push = (gnt0 && (rq0_cmd == CmdRead)) || (gnt1 && (rq1_cmd == CmdRead));
    end

    always_comb begin
        mem_cmd_d    = mem_cmd_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        last_grant_d = last_grant_q;
        if (slot_free) begin
            if (gnt0) begin
                mem_cmd_d    = rq0_cmd;
                mem_addr_d   = rq0_addr;
                mem_wdata_d  = rq0_wdata;
                last_grant_d = 1'b0;
            end else if (gnt1) begin
                mem_cmd_d    = rq1_cmd;
                mem_addr_d   = rq1_addr;
                mem_wdata_d  = rq1_wdata;
                last_grant_d = 1'b1;
            end else begin
                mem_cmd_d = CmdNoOp;
            end
        end
    end

    always_comb begin
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            tags_d[wr_ptr_q] = gnt1;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_cmd_q    <= CmdNoOp;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            last_grant_q <= 1'b1;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            tags_q       <= '0;
        end else begin
            mem_cmd_q    <= mem_cmd_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            tags_q       <= tags_d;
        end
    end

    // Combinational outputs are gated so they read as idle while reset is held.
    always_comb begin
        mem_cmd    = mem_cmd_q;
        mem_addr   = mem_addr_q;
        mem_wdata  = mem_wdata_q;
        rq0_ready  = gnt0;
        rq1_ready  = gnt1;
        rd_data    = mem_rdata;
        rq0_rvalid = pop && !tags_q[rd_ptr_q];
        rq1_rvalid = pop && tags_q[rd_ptr_q];
        err        = reset_n && (!legal0 || !legal1 || (mem_rvalid && (count_q == '0)));
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed checks of mem_port_arbiter followed by a randomized run scored
// against per-port expected issue and read-data queues.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [5:0]  rq0_cmd, rq1_cmd;
    logic [29:0] rq0_addr, rq1_addr;
    logic [31:0] rq0_wdata, rq1_wdata;
    logic        rq0_ready, rq1_ready, rq0_rvalid, rq1_rvalid;
    logic [31:0] rd_data;
    logic [5:0]  mem_cmd;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wait, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    mem_port_arbiter #(.ADDR_W(30), .DATA_W(32), .MAX_OUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .rq0_cmd(rq0_cmd), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
        .rq0_ready(rq0_ready), .rq0_rvalid(rq0_rvalid),
        .rq1_cmd(rq1_cmd), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
        .rq1_ready(rq1_ready), .rq1_rvalid(rq1_rvalid),
        .rd_data(rd_data), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wait(mem_wait), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] READ = 6'b100000;

    typedef struct packed {
        logic [5:0]  cmd;
        logic [29:0] addr;
        logic [31:0] wdata;
    } iss_t;

    iss_t        exp_issue[$];
    logic [31:0] exp_rd0[$], exp_rd1[$], mem_pend[$];

    int vectors = 0;
    int miscompares = 0;
    bit sb_on = 1'b0;
    bit acc0, acc1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {a, 2'b00} ^ 32'hA5C3_0F96;
    endfunction

    function automatic logic [5:0] rand_cmd();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return 6'b000000;
        if (r < 6) return READ;
        case ($urandom_range(0, 6))
            0:       return 6'b011111;
            1:       return 6'b011100;
            2:       return 6'b010011;
            3:       return 6'b011000;
            4:       return 6'b010100;
            5:       return 6'b010010;
            default: return 6'b010001;
        endcase
    endfunction

    task automatic clear_inputs;
        rq0_cmd = '0; rq0_addr = '0; rq0_wdata = '0;
        rq1_cmd = '0; rq1_addr = '0; rq1_wdata = '0;
        mem_wait = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // One environment cycle: record acceptances and memory issues at the falling
    // edge, then drive new requester and memory inputs just after the rising edge.
    task automatic env_cycle(input bit gen);
        @(negedge clk);
        if (rq0_ready) begin
            exp_issue.push_back('{rq0_cmd, rq0_addr, rq0_wdata});
            if (rq0_cmd == READ) exp_rd0.push_back(mem_word(rq0_addr));
            acc0 = 1'b1;
        end
        if (rq1_ready) begin
            exp_issue.push_back('{rq1_cmd, rq1_addr, rq1_wdata});
            if (rq1_cmd == READ) exp_rd1.push_back(mem_word(rq1_addr));
            acc1 = 1'b1;
        end
        if (mem_cmd == READ && !mem_wait) mem_pend.push_back(mem_word(mem_addr));
        step();
        if (!gen) begin
            rq0_cmd = '0;
            rq1_cmd = '0;
        end else begin
            if (acc0 || rq0_cmd == '0) begin
                rq0_cmd = rand_cmd(); rq0_addr = 30'($urandom); rq0_wdata = $urandom;
                acc0 = 1'b0;
            end
            if (acc1 || rq1_cmd == '0) begin
                rq1_cmd = rand_cmd(); rq1_addr = 30'($urandom); rq1_wdata = $urandom;
                acc1 = 1'b0;
            end
        end
        mem_wait = gen && ($urandom_range(0, 3) == 0);
        if (mem_pend.size() != 0 && $urandom_range(0, 1) == 1) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_pend.pop_front();
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
    endtask

    // Scoreboard monitor.
    initial begin
        iss_t saved, cur, e;
        bit   stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (sb_on) begin
                cur = '{mem_cmd, mem_addr, mem_wdata};
                chk("err_idle", 64'(err), 64'(0));
                chk("single_winner", 64'(rq0_ready & rq1_ready), 64'(0));
                chk("rvalid_count", 64'(int'(rq0_rvalid) + int'(rq1_rvalid)), 64'(mem_rvalid));
                if (rq0_rvalid) begin
                    if (exp_rd0.size() == 0) chk("rd0_unexpected", 64'(1), 64'(0));
                    else chk("rd0_data", 64'(rd_data), 64'(exp_rd0.pop_front()));
                end
                if (rq1_rvalid) begin
                    if (exp_rd1.size() == 0) chk("rd1_unexpected", 64'(1), 64'(0));
                    else chk("rd1_data", 64'(rd_data), 64'(exp_rd1.pop_front()));
                end
                if (stall_prev) chk("stall_hold", 64'(cur == saved), 64'(1));
                if (mem_cmd != '0 && mem_wait)
                    chk("stall_ready", 64'(rq0_ready | rq1_ready), 64'(0));
                if (mem_cmd != '0 && !mem_wait) begin
                    if (exp_issue.size() == 0) begin
                        chk("issue_unexpected", 64'(mem_cmd), 64'(0));
                    end else begin
                        e = exp_issue.pop_front();
                        chk("issue_cmd", 64'(mem_cmd), 64'(e.cmd));
                        chk("issue_addr", 64'(mem_addr), 64'(e.addr));
                        chk("issue_wdata", 64'(mem_wdata), 64'(e.wdata));
                    end
                end
                stall_prev = (mem_cmd != '0) && mem_wait;
                saved      = cur;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        reset_n = 1'b1;
        acc0 = 1'b0;
        acc1 = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        chk("rst_mem_cmd", 64'(mem_cmd), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_flags", 64'({rq0_ready, rq1_ready, rq0_rvalid, rq1_rvalid, err}), 64'(0));
        step();
        reset_n = 1'b1;
        step();

        // Single read with response three cycles later.
        rq0_cmd = READ; rq0_addr = 30'h10;
        #1 chk("rd_ready", 64'({rq0_ready, rq1_ready}), 64'(2'b10));
        step();
        rq0_cmd = '0;
        chk("rd_mem_cmd", 64'(mem_cmd), 64'(READ));
        chk("rd_mem_addr", 64'(mem_addr), 64'(30'h10));
        step();
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1 chk("rd_rvalid", 64'({rq0_rvalid, rq1_rvalid}), 64'(2'b10));
        chk("rd_data", 64'(rd_data), 64'(32'hDEADBEEF));
        step();
        mem_rvalid = 1'b0;

        // Tie: alternating grants starting with port 0, then in-order routing.
        do_reset();
        rq0_cmd = READ; rq0_addr = 30'h20;
        rq1_cmd = READ; rq1_addr = 30'h30;
        for (int i = 0; i < 4; i++) begin
            #1 chk("tie_grant", 64'({rq0_ready, rq1_ready}), (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
            step();
        end
        rq0_cmd = '0; rq1_cmd = '0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'(i + 100);
            #1 chk("tie_route", 64'({rq0_rvalid, rq1_rvalid}),
                   (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
            step();
        end
        mem_rvalid = 1'b0;
        rq1_cmd = 6'b010010; rq1_addr = 30'h5; rq1_wdata = 32'h0000AB00;
        #1 chk("wb2_ready", 64'(rq1_ready), 64'(1));
        step();
        rq1_cmd = '0;
        chk("wb2_mem_cmd", 64'(mem_cmd), 64'(6'b010010));

        // Stall holds the output register and blocks grants.
        do_reset();
        rq0_cmd = 6'b011111; rq0_addr = 30'h4; rq0_wdata = 32'h12345678;
        #1 chk("st_ready", 64'(rq0_ready), 64'(1));
        step();
        rq0_cmd = '0; mem_wait = 1'b1;
        rq1_cmd = READ; rq1_addr = 30'h40;
        for (int i = 0; i < 3; i++) begin
            #1 chk("st_hold", 64'({mem_cmd, mem_addr, mem_wdata}),
                   64'({6'b011111, 30'h4, 32'h12345678}));
            chk("st_noready", 64'({rq0_ready, rq1_ready}), 64'(0));
            step();
        end
        mem_wait = 1'b0;
        #1 chk("st_release_ready", 64'(rq1_ready), 64'(1));
        step();
        rq1_cmd = '0;
        chk("st_next_cmd", 64'({mem_cmd, mem_addr}), 64'({READ, 30'h40}));

        // FIFO full: fifth read waits, writes still pass, pop frees a slot same cycle.
        do_reset();
        rq1_cmd = READ; rq1_addr = 30'h60;
        for (int i = 0; i < 4; i++) begin
            #1 chk("ff_fill", 64'(rq1_ready), 64'(1));
            step();
        end
        #1 chk("ff_full", 64'(rq1_ready), 64'(0));
        rq0_cmd = 6'b011100; rq0_addr = 30'h8; rq0_wdata = 32'hCAFE0000;
        #1 chk("ff_write", 64'({rq0_ready, rq1_ready}), 64'(2'b10));
        step();
        rq0_cmd = '0;
        mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
        #1 chk("ff_pop_push", 64'({rq1_rvalid, rq1_ready, rq0_rvalid}), 64'(3'b110));
        step();
        mem_rvalid = 1'b0; rq1_cmd = '0;

        // Protocol errors.
        do_reset();
        rq0_cmd = 6'b110000;
        for (int i = 0; i < 3; i++) begin
            #1 chk("ill_err", 64'({err, rq0_ready}), 64'(2'b10));
            step();
        end
        rq0_cmd = '0;
        #1 chk("ill_clear", 64'(err), 64'(0));
        mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
        #1 chk("unexp_rv", 64'({err, rq0_rvalid, rq1_rvalid}), 64'(3'b100));
        step();
        mem_rvalid = 1'b0;
        #1 chk("unexp_clear", 64'(err), 64'(0));

        // Asynchronous reset with reads outstanding.
        do_reset();
        rq0_cmd = READ; rq0_addr = 30'h55;
        step();
        step();
        rq0_cmd = '0; rq1_cmd = READ; rq1_addr = 30'h77;
        #1 chk("ar_pre_ready", 64'(rq1_ready), 64'(1));
        reset_n = 1'b0;
        #1 chk("ar_mem", 64'({mem_cmd, mem_addr, mem_wdata}), 64'(0));
        chk("ar_flags", 64'({rq0_ready, rq1_ready, rq0_rvalid, rq1_rvalid, err}), 64'(0));
        rq1_cmd = '0;
        #1 reset_n = 1'b1;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        #1 chk("ar_late_rv", 64'({err, rq0_rvalid, rq1_rvalid}), 64'(3'b100));
        step();
        mem_rvalid = 1'b0;

        // Randomized run against the scoreboard.
        do_reset();
        sb_on = 1'b1;
        for (int c = 0; c < 3000; c++) env_cycle(1'b1);
        for (int c = 0; c < 300; c++) begin
            if (exp_issue.size() == 0 && exp_rd0.size() == 0 && exp_rd1.size() == 0 &&
                mem_pend.size() == 0 && !mem_rvalid)
                break;
            env_cycle(1'b0);
        end
        @(negedge clk);
        sb_on = 1'b0;
        chk("drain_issue", 64'(exp_issue.size()), 64'(0));
        chk("drain_rd0", 64'(exp_rd0.size()), 64'(0));
        chk("drain_rd1", 64'(exp_rd1.size()), 64'(0));
        chk("drain_mem", 64'(mem_pend.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
